shift_seq_ctrl: RTL and testbench



---
 rtl/shift_seq_pkg.sv | 31 +++
 rtl/shift_step_reg.sv | 50 +++++
 rtl/shift_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared types and helpers for the one-bit-per-cycle shift sequencer.
//   state_e      : sequencer states (IDLE / SHIFT / DONE)
//   DIR_* MODE_* : encodings of the request direction and fill mode bits
//   eff_count()  : number of single-bit steps a request needs
// -----------------------------------------------------------------------------
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;
  localparam logic MODE_LOGICAL = 1'b0;
  localparam logic MODE_ROTATE  = 1'b1;

  // A logical shift by WIDTH or more already yields all zeros, so the step
  // count is clamped there. A rotation is stepped the full requested amount,
  // which naturally gives a rotation by amt mod width.
  function automatic logic [31:0] eff_count(input logic [31:0] amt,
                                            input logic        rot,
                                            input logic [31:0] width);
    if (rot == MODE_ROTATE) return amt;
    return (amt > width) ? width : amt;
  endfunction

endpackage

// File: rtl/shift_step_reg.sv
// -----------------------------------------------------------------------------
// shift_step_reg
// WIDTH-bit register that either loads a word or moves it by one bit position.
//   clk, clr   : clock, synchronous active-high clear (register -> 0)
//   load       : capture load_data (has priority over step)
//   load_data  : word to capture
//   step       : move one position this edge
//   dir        : DIR_LEFT / DIR_RIGHT
//   rot        : MODE_LOGICAL (zero fill) / MODE_ROTATE (wrap the bit out)
//   q          : current register contents
// -----------------------------------------------------------------------------
module shift_step_reg
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             step,
  input  logic             dir,
  input  logic             rot,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_data;
    end else if (step) begin
      if (dir == DIR_LEFT) begin
        q_d = {q_q[WIDTH-2:0], (rot == MODE_ROTATE) ? q_q[WIDTH-1] : 1'b0};
      end else begin
        q_d = {(rot == MODE_ROTATE) ? q_q[0] : 1'b0, q_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
// Sequencer for the one-bit-per-cycle variable shifter. Accepts a shift
// request, steps the shift register once per enabled clock, then presents the
// result until the consumer takes it.
//   clk, clr              : clock, synchronous active-high clear
//   en                    : step enable (only affects SHIFT)
//   req_valid/req_ready   : request handshake
//   req_data/amt/dir/rot  : operand, shift amount, direction, rotate flag
//   abort                 : cancel the in-flight operation (no response)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data              : shift register contents (meaningful when rsp_valid)
//   busy                  : state != IDLE
//   ops_done              : count of completed response handshakes, wraps
// -----------------------------------------------------------------------------
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 6,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [SHW-1:0]   req_amt,
  input  logic             req_dir,
  input  logic             req_rot,
  input  logic             abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [CNTW-1:0]  ops_done
);

  state_e          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            rot_q, rot_d;
  logic [CNTW-1:0] ops_q, ops_d;
  logic            load;
  logic            step;
  logic [31:0]     n_req;

  assign n_req = eff_count(32'(req_amt), req_rot, 32'(WIDTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    ops_d   = ops_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !abort) begin
          load  = 1'b1;
          dir_d = req_dir;
          rot_d = req_rot;
          if (n_req != '0) begin
            state_d = SHIFT;
            // n_req never exceeds req_amt, so it always fits in SHW bits.
            cnt_d   = n_req[SHW-1:0];
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (en) begin
          step  = 1'b1;
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        // An abort in the handshake cycle cancels the response uncounted.
        if (abort) begin
          state_d = IDLE;
        end else if (rsp_ready) begin
          state_d = IDLE;
          ops_d   = ops_q + CNTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
      rot_q   <= MODE_LOGICAL;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      ops_q   <= ops_d;
    end
  end

  // Direction and mode are latched at accept, so the step engine only sees
  // the captured copies while shifting.
  shift_step_reg #(
    .WIDTH(WIDTH)
  ) u_step (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .load_data(req_data),
    .step     (step),
    .dir      (dir_q),
    .rot      (rot_q),
    .q        (rsp_data)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Directed bench for shift_seq_ctrl with a transaction-level reference model
// compared against the outputs every cycle, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int SHW   = 6;
  localparam int CNTW  = 16;

  logic             clk = 1'b0;
  logic             clr, en, req_valid, req_dir, req_rot, abort, rsp_ready;
  logic [WIDTH-1:0] req_data;
  logic [SHW-1:0]   req_amt;
  logic             req_ready, rsp_valid, busy;
  logic [WIDTH-1:0] rsp_data;
  logic [CNTW-1:0]  ops_done;

  shift_seq_ctrl #(.WIDTH(WIDTH), .SHW(SHW), .CNTW(CNTW)) dut (
    .clk(clk), .clr(clr), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_amt(req_amt), .req_dir(req_dir), .req_rot(req_rot),
    .abort(abort), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  bit chk_on  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result of a whole request computed directly, not bit by bit.
  function automatic logic [31:0] ref_result(input logic [31:0] x, input int amt,
                                             input logic dir, input logic rot);
    logic [63:0] dbl;
    int k;
    if (rot) begin
      k   = amt % WIDTH;
      dbl = {x, x};
      if (!dir) begin
        dbl = dbl << k;
        return dbl[63:32];
      end
      dbl = dbl >> k;
      return dbl[31:0];
    end
    if (amt >= WIDTH) return 32'h0;
    return dir ? (x >> amt) : (x << amt);
  endfunction

  function automatic int ref_count(input int amt, input logic rot);
    if (rot) return amt;
    return (amt > WIDTH) ? WIDTH : amt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting for work, 1 = steps outstanding,
  // 2 = result on offer.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_res   = '0;
  int          m_ops   = 0;

  always @(posedge clk) begin
    if (clr) begin
      m_phase <= 0;
      m_left  <= 0;
      m_ops   <= 0;
    end else begin
      case (m_phase)
        0: if (req_valid && !abort) begin
             m_res <= ref_result(req_data, int'(req_amt), req_dir, req_rot);
             if (ref_count(int'(req_amt), req_rot) == 0) m_phase <= 2;
             else begin
               m_phase <= 1;
               m_left  <= ref_count(int'(req_amt), req_rot);
             end
           end
        1: if (abort) m_phase <= 0;
           else if (en) begin
             m_left <= m_left - 1;
             if (m_left == 1) m_phase <= 2;
           end
        default: if (abort) m_phase <= 0;
                 else if (rsp_ready) begin
                   m_phase <= 0;
                   m_ops   <= (m_ops + 1) % (1 << CNTW);
                 end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, m_phase == 0});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_phase == 2});
      chk("busy",      {31'b0, busy},      {31'b0, m_phase != 0});
      chk("ops_done",  32'(ops_done),      32'(m_ops));
      if (m_phase == 2) chk("rsp_data", rsp_data, m_res);
    end
  end

  // Edge numbers of the most recent request accept and response handshake.
  int acc_cnt = 0, last_acc = 0, last_hs = 0;
  always @(negedge clk) begin
    if (!clr && req_valid && req_ready && !abort) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= cyc + 1;
    end
    if (!clr && rsp_valid && rsp_ready && !abort) last_hs <= cyc + 1;
  end

  task automatic send(input logic [31:0] d, input int amt, input logic dir, input logic rot);
    bit r;
    int guard;
    req_data  = d;
    req_amt   = SHW'(amt);
    req_dir   = dir;
    req_rot   = rot;
    req_valid = 1'b1;
    guard     = 0;
    do begin
      @(negedge clk);
      r = req_ready;
      @(posedge clk);
      guard++;
    end while (!r && guard < 200);
    #1;
    req_valid = 1'b0;
    if (!r) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // lat = edges after the accept edge until rsp_valid is seen high.
  task automatic wait_rsp(output int lat, output logic [31:0] data);
    lat = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      if (lat >= 200) begin
        chk("rsp_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    data = rsp_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] d;
    int          base;
    int          guard;

    clr = 1'b1; en = 1'b1; req_valid = 1'b0; req_dir = 1'b0; req_rot = 1'b0;
    abort = 1'b0; rsp_ready = 1'b1; req_data = '0; req_amt = '0;

    @(posedge clk); #1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data",  rsp_data,          32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_ops_done",  32'(ops_done),      32'd0);
    @(posedge clk); #1;
    clr = 1'b0;

    // Logical left 4
    send(32'h0000_01A6, 4, 1'b0, 1'b0);
    wait_rsp(lat, d);
    chk("t1_lat",  32'(lat), 32'd4);
    chk("t1_data", d, 32'h0000_1A60);
    @(posedge clk); #1;
    chk("t1_ops", 32'(ops_done), 32'd1);

    // Rotate right 3, rotate left 40
    send(32'h0000_0001, 3, 1'b1, 1'b1);
    wait_rsp(lat, d);
    chk("t2a_lat",  32'(lat), 32'd3);
    chk("t2a_data", d, 32'h2000_0000);
    @(posedge clk); #1;
    send(32'h0000_01A6, 40, 1'b0, 1'b1);
    wait_rsp(lat, d);
    chk("t2b_lat",  32'(lat), 32'd40);
    chk("t2b_data", d, 32'h0001_A600);
    @(posedge clk); #1;

    // Clamped logical right, zero amount
    send(32'hFFFF_FFFF, 63, 1'b1, 1'b0);
    wait_rsp(lat, d);
    chk("t3a_lat",  32'(lat), 32'd32);
    chk("t3a_data", d, 32'h0000_0000);
    @(posedge clk); #1;
    send(32'h1234_5678, 0, 1'b0, 1'b0);
    wait_rsp(lat, d);
    chk("t3b_lat",  32'(lat), 32'd0);
    chk("t3b_data", d, 32'h1234_5678);
    @(posedge clk); #1;

    // Stall: en low for three edges mid-shift
    send(32'h0000_01A6, 4, 1'b0, 1'b0);
    fork
      begin
        repeat (2) @(posedge clk);
        #1 en = 1'b0;
        repeat (3) @(posedge clk);
        #1 en = 1'b1;
      end
      wait_rsp(lat, d);
    join
    chk("t4a_lat",  32'(lat), 32'd7);
    chk("t4a_data", d, 32'h0000_1A60);
    @(posedge clk); #1;

    // Backpressure for five cycles
    rsp_ready = 1'b0;
    send(32'h0000_01A6, 4, 1'b0, 1'b0);
    wait_rsp(lat, d);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t4b_valid", {31'b0, rsp_valid}, 32'd1);
      chk("t4b_data",  rsp_data, 32'h0000_1A60);
      chk("t4b_ready", {31'b0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4b_ops", 32'(ops_done), 32'd7);

    // Abort on the second shift cycle
    send(32'h0000_01A6, 4, 1'b0, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t5_busy",  {31'b0, busy}, 32'd0);
    chk("t5_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t5_ops",   32'(ops_done), 32'd7);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Clear while a result is held
    rsp_ready = 1'b0;
    send(32'hCAFE_F00D, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5c_held", {31'b0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5c_req_ready", {31'b0, req_ready}, 32'd1);
    chk("t5c_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t5c_rsp_data",  rsp_data, 32'd0);
    chk("t5c_busy",      {31'b0, busy}, 32'd0);
    chk("t5c_ops",       32'(ops_done), 32'd0);
    @(posedge clk); #1;
    send(32'h0000_000F, 2, 1'b0, 1'b0);
    wait_rsp(lat, d);
    chk("t5d_data", d, 32'h0000_003C);
    @(posedge clk); #1;
    chk("t5d_ops", 32'(ops_done), 32'd1);

    // Back-to-back with req_valid held high
    clr = 1'b1;
    @(posedge clk); #1;
    clr       = 1'b0;
    base      = acc_cnt;
    req_data  = 32'h0000_0001; req_amt = 6'd1; req_dir = 1'b0; req_rot = 1'b0;
    req_valid = 1'b1;
    guard     = 0;
    while (acc_cnt < base + 1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    req_data = 32'h0000_0003; req_amt = 6'd2;
    guard    = 0;
    while (acc_cnt < base + 2 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    req_valid = 1'b0;
    chk("t6_accepts", 32'(acc_cnt - base), 32'd2);
    chk("t6_gap",     32'(last_acc), 32'(last_hs + 1));
    wait_rsp(lat, d);
    chk("t6_data", d, 32'h0000_000C);
    @(posedge clk); #1;
    chk("t6_ops", 32'(ops_done), 32'd2);

    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
